// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state type, lane legality and Rcon lookup for key_word_xform
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_XOR  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

  function automatic logic rcon_legal(input logic [31:0] round);
    return (round >= 32'd1) && (round <= 32'd10);
  endfunction

  function automatic logic [7:0] rcon_lookup(input logic [31:0] round);
    logic [7:0] rc;
    case (round)
      32'd1:   rc = 8'h01;
      32'd2:   rc = 8'h02;
      32'd3:   rc = 8'h04;
      32'd4:   rc = 8'h08;
      32'd5:   rc = 8'h10;
      32'd6:   rc = 8'h20;
      32'd7:   rc = 8'h40;
      32'd8:   rc = 8'h80;
      32'd9:   rc = 8'h1b;
      32'd10:  rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/sbytes.sv
// rtl/sbytes.sv - combinational single-byte AES forward S-box
module sbytes (
  input  logic [7:0] olddata,
  output logic [7:0] newdata
);

  // Entry 0 sits in the top byte, so the lookup index is the inverted input.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] w_inv;
  assign w_inv   = ~olddata;
  assign newdata = SBOX[{w_inv, 3'b000} +: 8];

endmodule

// File: rtl/key_word_xform.sv
// rtl/key_word_xform.sv - AES key-schedule G/H word transform, 1/2/4 S-box lanes per cycle
module key_word_xform #(
  parameter int LANES   = 1,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        word_in,
  input  logic               mode_h,
  input  logic [ROUND_W-1:0] round_num,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        word_out,
  output logic               out_err
);
  import key_pkg::*;

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("key_word_xform: LANES must be 1, 2 or 4");
  end

  localparam int PASSES = 4 / LANES;

  state_t      r_state, w_next;
  logic [31:0] r_tmp;
  logic [1:0]  r_pass;
  logic        r_mode_h;
  logic [7:0]  r_rcon;
  logic        r_err;
  logic [31:0] r_word_out;
  logic        r_out_err;

  logic [31:0] w_round_ext;
  logic        w_last_pass;
  logic [1:0]  w_idx [LANES];
  logic [7:0]  w_old [LANES];
  logic [7:0]  w_new [LANES];

  assign w_round_ext = 32'(round_num);
  assign w_last_pass = (r_pass == 2'(PASSES - 1));

  // Each lane owns one byte of the current pass; pass 0 starts at the LSB byte.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_idx[l] = 2'(int'(r_pass) * LANES + l);
    assign w_old[l] = r_tmp[{w_idx[l], 3'b000} +: 8];
    sbytes u_sbytes (
      .olddata (w_old[l]),
      .newdata (w_new[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)    w_next = ST_SUB;
      ST_SUB:  if (w_last_pass) w_next = ST_XOR;
      ST_XOR:                   w_next = ST_OUT;
      ST_OUT:  if (out_ready)   w_next = ST_IDLE;
      default:                  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_OUT);
  end

  assign word_out = r_word_out;
  assign out_err  = r_out_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmp      <= '0;
      r_pass     <= '0;
      r_mode_h   <= 1'b0;
      r_rcon     <= '0;
      r_err      <= 1'b0;
      r_word_out <= '0;
      r_out_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_tmp    <= mode_h ? word_in : {word_in[23:0], word_in[31:24]};
            r_mode_h <= mode_h;
            r_rcon   <= mode_h ? 8'h00 : rcon_lookup(w_round_ext);
            r_err    <= !mode_h && !rcon_legal(w_round_ext);
            r_pass   <= '0;
          end
        end
        ST_SUB: begin
          for (int l = 0; l < LANES; l++) begin
            r_tmp[{w_idx[l], 3'b000} +: 8] <= w_new[l];
          end
          r_pass <= r_pass + 2'd1;
        end
        ST_XOR: begin
          r_word_out <= r_mode_h ? r_tmp : {r_tmp[31:24] ^ r_rcon, r_tmp[23:0]};
          r_out_err  <= r_err;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_word_xform.sv
// tb/tb_key_word_xform.sv - scoreboard bench for key_word_xform at LANES 1, 2 and 4
module tb_key_word_xform;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0]       in_valid, in_ready, mode_h, out_valid, out_ready, out_err;
  logic [NI-1:0][31:0] word_in, word_out;
  logic [NI-1:0][3:0]  round_num;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    key_word_xform #(.LANES(1 << k), .ROUND_W(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .word_in   (word_in[k]),
      .mode_h    (mode_h[k]),
      .round_num (round_num[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .word_out  (word_out[k]),
      .out_err   (out_err[k])
    );
  end

  typedef struct {
    logic [31:0] w;
    logic        e;
    int          t;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s bound expired at cycle %0d", nm, cyc);
  endtask

  // Reference model: GF(2^8) arithmetic rather than a lookup table.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} >> (8 - n);
    return d[7:0];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input int r);
    logic [7:0] rc = 8'h01;
    if (r < 1 || r > 10) return 8'h00;
    for (int i = 1; i < r; i++) rc = xt(rc);
    return rc;
  endfunction

  task automatic model(input logic [31:0] w, input logic m, input logic [3:0] r,
                       output logic [31:0] ew, output logic ee);
    logic [31:0] src;
    src = m ? w : ((w << 8) | (w >> 24));
    for (int i = 0; i < 4; i++) ew[8*i +: 8] = sbox_ref(src[8*i +: 8]);
    if (!m) ew[31:24] = ew[31:24] ^ rcon_ref(int'(r));
    ee = !m && (r < 4'd1 || r > 4'd10);
  endtask

  task automatic qpush(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    case (k)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // t_acc is the cycle number of the accept cycle; latency is counted from it.
  task automatic send(input int k, input logic [31:0] w, input logic m, input logic [3:0] r,
                      input logic [31:0] ew, input logic ee, input bit do_push,
                      output int t_acc);
    exp_t e;
    int n = 0;
    t_acc = 0;
    @(negedge clk);
    in_valid[k] = 1'b1; word_in[k] = w; mode_h[k] = m; round_num[k] = r;
    while (!in_ready[k] && n < 200) begin @(negedge clk); n++; end
    if (!in_ready[k]) begin
      fail_now("accept_timeout");
      in_valid[k] = 1'b0;
      return;
    end
    t_acc = cyc;
    e.w = ew; e.e = ee; e.t = cyc;
    if (do_push) qpush(k, e);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0; word_in[k] = $urandom; mode_h[k] = 1'($urandom); round_num[k] = 4'($urandom);
  endtask

  task automatic send_rand(input int k, input bit do_push, output int t_acc);
    logic [31:0] w, ew;
    logic m, ee;
    logic [3:0] r;
    w = $urandom; m = 1'($urandom_range(0, 1)); r = 4'($urandom_range(0, 15));
    model(w, m, r, ew, ee);
    send(k, w, m, r, ew, ee, do_push, t_acc);
  endtask

  task automatic wait_valid(input int k);
    int n = 0;
    while (!out_valid[k] && n < 50) begin @(negedge clk); n++; end
    if (!out_valid[k]) fail_now("valid_timeout");
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    out_ready = '1;
    while ((q0.size() + q1.size() + q2.size() != 0 || in_ready != '1) && n < 300) begin
      @(negedge clk); n++;
    end
    chk("drain_queue", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    chk("drain_idle", 32'(in_ready), 32'(3'b111));
  endtask

  task automatic rand_thread(input int k);
    int t;
    for (int i = 0; i < 25; i++) begin
      out_ready[k] = 1'($urandom_range(0, 1));
      send_rand(k, 1'b1, t);
      wait_valid(k);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      out_ready[k] = 1'b1;
      @(negedge clk);
    end
  endtask

  // Monitor: 2 time units after each edge, so out_ready reads as it was at that edge.
  logic [NI-1:0]       pv = '0, pe = '0;
  logic [NI-1:0][31:0] pw = '0;
  always begin
    @(posedge clk);
    #2;
    for (int k = 0; k < NI; k++) begin
      if (out_valid[k]) begin
        if (pv[k] && !out_ready[k]) begin
          chk("hold_word", word_out[k], pw[k]);
          chk("hold_err", 32'(out_err[k]), 32'(pe[k]));
        end else if (!pv[k]) begin
          exp_t e;
          bit ok;
          qpop(k, e, ok);
          if (!ok) fail_now("unexpected_output");
          else begin
            chk($sformatf("word_L%0d", 1 << k), word_out[k], e.w);
            chk($sformatf("err_L%0d", 1 << k), 32'(out_err[k]), 32'(e.e));
            chk($sformatf("latency_L%0d", 1 << k), 32'(cyc - e.t), 32'(4 / (1 << k) + 2));
          end
        end else begin
          fail_now("valid_not_released");
        end
        chk("busy_in_ready", 32'(in_ready[k]), 32'd0);
      end
      pv[k] = out_valid[k];
      pw[k] = word_out[k];
      pe[k] = out_err[k];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t;
    logic [31:0] w, ew;
    logic ee;
    in_valid = '0; mode_h = '0; out_ready = '1; word_in = '0; round_num = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_in_ready", 32'(in_ready[k]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_out_err", 32'(out_err[k]), 32'd0);
      chk("rst_word_out", word_out[k], 32'd0);
    end
    rst = 1'b0;

    send(0, 32'h09cf4f3c, 1'b0, 4'd1, 32'h8b84eb01, 1'b0, 1'b1, t);
    send(2, 32'h09cf4f3c, 1'b1, 4'd7, 32'h018a84eb, 1'b0, 1'b1, t);
    send(1, 32'h00000000, 1'b0, 4'd9, 32'h78636363, 1'b0, 1'b1, t);
    send(1, 32'h00000000, 1'b0, 4'd0, 32'h63636363, 1'b1, 1'b1, t);
    send(2, 32'h00000000, 1'b1, 4'd0, 32'h63636363, 1'b0, 1'b1, t);
    send(2, 32'h00000000, 1'b0, 4'd10, 32'h55636363, 1'b0, 1'b1, t);
    drain();

    // Stalled consumer: result must hold and in_valid pulses must not be accepted.
    @(negedge clk);
    out_ready[0] = 1'b0;
    send_rand(0, 1'b1, t);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[0] = 1'(i % 2 == 0);
      word_in[0] = $urandom;
      chk("stall_in_ready", 32'(in_ready[0]), 32'd0);
      chk("stall_out_valid", 32'(out_valid[0]), 32'd1);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 32'(out_valid[0]), 32'd0);
    chk("release_in_ready", 32'(in_ready[0]), 32'd1);
    drain();

    // Reset during the third S-box pass aborts the request.
    send_rand(0, 1'b0, t);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort_out_valid", 32'(out_valid[0]), 32'd0);
    rst = 1'b0;
    w = 32'h2b7e1516;
    model(w, 1'b0, 4'd3, ew, ee);
    send(0, w, 1'b0, 4'd3, ew, ee, 1'b1, t);
    drain();

    // Back-to-back on LANES=2: second request waits while in_valid stays high.
    send_rand(1, 1'b1, t1);
    send_rand(1, 1'b1, t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd5);
    drain();

    fork
      rand_thread(0);
      rand_thread(1);
      rand_thread(2);
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
